// File: rtl/contador_descendente.sv
// -----------------------------------------------------------------------------
// contador_descendente
// Loadable synchronous down counter / countdown timer. Counts from a reload
// value down to 0 and raises a one-cycle registered terminal-count pulse.
// One-shot mode stops at 0. Auto-reload mode wraps 0 -> reload, which gives a
// modulo-(reload+1) down counter. Load values above the modulus are clamped.
// -----------------------------------------------------------------------------
module contador_descendente #(
   parameter int W   = 4,
   parameter int MOD = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         en,
   input  logic         auto,
   output logic [W-1:0] q,
   output logic         zero,
   output logic         tc,
   output logic         busy
);

   localparam logic [W-1:0] MAXV = W'(MOD - 1);
   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [0:0]   IDLE = 1'b0;
   localparam logic [0:0]   RUN  = 1'b1;

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] rl_q, rl_d;
   logic [0:0]   st_q, st_d;
   logic         tc_q, tc_d;
   logic [W-1:0] ld_v;

   // Values above the modulus are clamped so q can never leave 0..MOD-1.
   assign ld_v = (d > MAXV) ? MAXV : d;

   always_comb begin
      cnt_d = cnt_q;
      rl_d  = rl_q;
      st_d  = st_q;
      // tc is a pulse: it is only ever raised by the 1 -> 0 decrement.
      tc_d  = 1'b0;
      if (load) begin
         cnt_d = ld_v;
         if (ld_v != '0) begin
            rl_d = ld_v;
            st_d = RUN;
         end else begin
            // Loading 0 parks the counter but keeps the old reload value.
            st_d = IDLE;
         end
      end else if (en) begin
         if (st_q == IDLE) begin
            if (auto) begin
               cnt_d = rl_q;
               st_d  = RUN;
            end
         end else if (cnt_q == '0) begin
            // Only reachable in RUN when the last 1 -> 0 step saw auto=1.
            cnt_d = rl_q;
         end else begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
               tc_d = 1'b1;
               // auto is only consulted at the 1 -> 0 decision.
               if (!auto) st_d = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
         rl_q  <= MAXV;
         st_q  <= IDLE;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rl_q  <= rl_d;
         st_q  <= st_d;
         tc_q  <= tc_d;
      end
   end

   assign q    = cnt_q;
   assign zero = (cnt_q == '0);
   assign tc   = tc_q;
   assign busy = (st_q == RUN);

endmodule
